// File: rtl/inst_prefetch_buf_if.sv
// Fetch bus bundle for inst_prefetch_buf: instruction-memory req/ack handshake,
// IF/ID head-of-queue outputs, downstream stall and branch redirect.
interface inst_prefetch_buf_if;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;

   modport master (
      output mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o,
      input  mem_ack_i, mem_rdata_i, stall_i, flush_i, flush_pc_i
   );

   modport slave (
      input  mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o,
      output mem_ack_i, mem_rdata_i, stall_i, flush_i, flush_pc_i
   );
endinterface

// File: rtl/inst_prefetch_buf.sv
// Instruction fetch stage: sequential fetch FSM with req/ack memory handshake feeding a {pc, inst} FIFO.
// Define FETCH_STAT_EN to add bubble_cnt_o / drop_cnt_o statistics counters.
module inst_prefetch_buf #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   inst_prefetch_buf_if.master  bus
`ifdef FETCH_STAT_EN
   ,
   output logic [31:0]          bubble_cnt_o,
   output logic [31:0]          drop_cnt_o
`endif
);
   // state | meaning
   // IDLE  | no request outstanding; waits for FIFO room
   // REQ   | request at fetch_pc outstanding; response pushed on ack
   // DROP  | pre-flush request still outstanding; response discarded on ack
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [1:0]    state, state_nx;
   logic [31:0]   fetch_pc, fetch_pc_nx;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_after;
   logic          push, pop;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic          unused_flush_lsb;

   assign unused_flush_lsb = ^bus.flush_pc_i[1:0];

   assign bus.if_valid_o = (count != '0);
   assign bus.if_pc_o    = bus.if_valid_o ? pc_mem[rd_ptr]   : 32'd0;
   assign bus.if_inst_o  = bus.if_valid_o ? inst_mem[rd_ptr] : 32'd0;

   assign pop         = bus.if_valid_o && !bus.stall_i;
   assign count_after = count + CW'(1) - CW'(pop);

   always_comb begin
      state_nx    = state;
      fetch_pc_nx = fetch_pc;
      push        = 1'b0;
      if (bus.flush_i) begin
         fetch_pc_nx = {bus.flush_pc_i[31:2], 2'b00};
         // a pending unacked request cannot be withdrawn, so wait it out in DROP
         state_nx    = (state != IDLE && !bus.mem_ack_i) ? DROP : REQ;
      end else begin
         case (state)
            IDLE: if (count < FULL) state_nx = REQ;
            REQ: if (bus.mem_ack_i) begin
               push        = 1'b1;
               fetch_pc_nx = fetch_pc + 32'd4;
               state_nx    = (count_after < FULL) ? REQ : IDLE;
            end
            DROP: if (bus.mem_ack_i) state_nx = REQ;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         fetch_pc       <= RESET_PC;
         bus.mem_req_o  <= 1'b0;
         bus.mem_addr_o <= RESET_PC;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
      end else begin
         state         <= state_nx;
         fetch_pc      <= fetch_pc_nx;
         bus.mem_req_o <= (state_nx != IDLE);
         if (state_nx != DROP) bus.mem_addr_o <= fetch_pc_nx;
         if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= fetch_pc;
         inst_mem[wr_ptr] <= bus.mem_rdata_i;
      end
   end

`ifdef FETCH_STAT_EN
   logic drop_evt;
   assign drop_evt = bus.mem_ack_i && ((state == DROP) || (state == REQ && bus.flush_i));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt_o <= 32'd0;
         drop_cnt_o   <= 32'd0;
      end else begin
         if (!bus.if_valid_o) bubble_cnt_o <= bubble_cnt_o + 32'd1;
         if (drop_evt)        drop_cnt_o   <= drop_cnt_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Self-checking bench for inst_prefetch_buf: random stimulus against a queue-based fetch model,
// plus directed redirect, full-FIFO and address-wrap scenarios.
module tb_inst_prefetch_buf;
   localparam int unsigned DEPTH   = 4;
   localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;

   logic clk, rst;
   int   n_tests, n_fail;

   inst_prefetch_buf_if bus_if();
   inst_prefetch_buf_if wrap_if();

`ifdef FETCH_STAT_EN
   logic [31:0] bubble_cnt, drop_cnt, w_bubble, w_drop;
`endif

   inst_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .bus(bus_if)
`ifdef FETCH_STAT_EN
      , .bubble_cnt_o(bubble_cnt), .drop_cnt_o(drop_cnt)
`endif
   );

   inst_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst), .bus(wrap_if)
`ifdef FETCH_STAT_EN
      , .bubble_cnt_o(w_bubble), .drop_cnt_o(w_drop)
`endif
   );

   // free-running ROM with ack tied to request
   assign wrap_if.mem_ack_i   = wrap_if.mem_req_o;
   assign wrap_if.mem_rdata_i = wrap_if.mem_addr_o ^ ROM_KEY;
   assign wrap_if.stall_i     = 1'b0;
   assign wrap_if.flush_i     = 1'b0;
   assign wrap_if.flush_pc_i  = 32'd0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   // reference model: queue of {pc, inst}, fetch pointer, outstanding/stale request flags
   logic [63:0] mq[$];
   logic [31:0] m_pc, m_addr, m_bubble, m_drop;
   bit          busy, stale;

   int          ack_mode, ack_pct, stall_pct, flush_pct, wcnt;
   bit          ovr_flush, wrap_rec;
   logic [31:0] ovr_fpc;
   logic [63:0] wq[$];
   logic [31:0] wrap_exp [3];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc     = 32'h0;
      m_addr   = 32'h0;
      m_bubble = 32'd0;
      m_drop   = 32'd0;
      busy     = 1'b0;
      stale    = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit f, input logic [31:0] fpc, input bit a);
      int pre;
      bit pop, ackd;
      pre  = mq.size();
      pop  = (pre != 0) && !s;
      ackd = busy && a;
      if (pre == 0) m_bubble++;
      if (f) begin
         if (ackd) m_drop++;
         mq.delete();
         m_pc = {fpc[31:2], 2'b00};
         if (busy && !a) stale = 1'b1;
         else begin
            stale  = 1'b0;
            busy   = 1'b1;
            m_addr = m_pc;
         end
      end else begin
         if (pop) void'(mq.pop_front());
         if (stale) begin
            if (a) begin
               m_drop++;
               stale  = 1'b0;
               m_addr = m_pc;
            end
         end else if (busy) begin
            if (a) begin
               mq.push_back({m_addr, m_addr ^ ROM_KEY});
               m_pc   = m_pc + 32'd4;
               m_addr = m_pc;
               busy   = (mq.size() < DEPTH);
            end
         end else begin
            busy   = (pre < DEPTH);
            m_addr = m_pc;
         end
      end
   endtask

   task automatic check_outputs();
      logic [63:0] head;
      head = (mq.size() != 0) ? mq[0] : 64'd0;
      chk("mem_req", 32'(bus_if.mem_req_o), 32'(busy));
      if (busy) chk("mem_addr", bus_if.mem_addr_o, m_addr);
      chk("if_valid", 32'(bus_if.if_valid_o), 32'(mq.size() != 0));
      chk("if_pc", bus_if.if_pc_o, head[63:32]);
      chk("if_inst", bus_if.if_inst_o, head[31:0]);
      if (wrap_rec && wrap_if.if_valid_o && wq.size() < 3)
         wq.push_back({wrap_if.if_pc_o, wrap_if.if_inst_o});
   endtask

   // one clock: compare at negedge, drive inputs, advance model, wait for next negedge
   task automatic cycle();
      bit s, f, a;
      logic [31:0] fpc;
      check_outputs();
      s   = ($urandom_range(99) < stall_pct);
      f   = ($urandom_range(99) < flush_pct);
      fpc = $urandom();
      case (ack_mode)
         0:       a = 1'b1;
         1:       a = (wcnt == 3);
         default: a = ($urandom_range(99) < ack_pct);
      endcase
      if (ovr_flush) begin
         f   = 1'b1;
         fpc = ovr_fpc;
      end
      a = a && bus_if.mem_req_o;
      if (bus_if.mem_req_o) wcnt = a ? 0 : wcnt + 1;
      else                  wcnt = 0;
      bus_if.stall_i     = s;
      bus_if.flush_i     = f;
      bus_if.flush_pc_i  = fpc;
      bus_if.mem_ack_i   = a;
      bus_if.mem_rdata_i = a ? (bus_if.mem_addr_o ^ ROM_KEY) : $urandom();
      model_step(s, f, fpc, a);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst                = 1'b0;
      bus_if.stall_i     = 1'b0;
      bus_if.flush_i     = 1'b0;
      bus_if.flush_pc_i  = 32'd0;
      bus_if.mem_ack_i   = 1'b0;
      bus_if.mem_rdata_i = 32'd0;
      #1;
      chk("rst_async_req", 32'(bus_if.mem_req_o), 32'd0);
      model_reset();
      wcnt = 0;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(bus_if.mem_req_o), 32'd0);
      chk("rst_addr", bus_if.mem_addr_o, 32'h0);
      chk("rst_valid", 32'(bus_if.if_valid_o), 32'd0);
      chk("rst_pc", bus_if.if_pc_o, 32'd0);
      chk("rst_inst", bus_if.if_inst_o, 32'd0);
      chk("rst_wrap_req", 32'(wrap_if.mem_req_o), 32'd0);
      chk("rst_wrap_addr", wrap_if.mem_addr_o, 32'hFFFF_FFF8);
`ifdef FETCH_STAT_EN
      chk("rst_bubble", bubble_cnt, 32'd0);
      chk("rst_drop", drop_cnt, 32'd0);
`endif
      rst = 1'b1;
   endtask

   initial begin
      int guard;
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b0;
      ovr_flush = 1'b0;
      ovr_fpc   = 32'd0;
      wrap_rec  = 1'b0;
      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;
      model_reset();

      // streaming fetch with ack tied high; wrap instance runs alongside
      do_reset();
      ack_mode = 0; stall_pct = 0; flush_pct = 0; ack_pct = 100;
      wrap_rec = 1'b1;
      repeat (12) cycle();
      wrap_rec = 1'b0;
      chk("wrap_count", 32'(wq.size()), 32'd3);
      for (int i = 0; i < wq.size(); i++) begin
         chk("wrap_pc", wq[i][63:32], wrap_exp[i]);
         chk("wrap_inst", wq[i][31:0], wrap_exp[i] ^ ROM_KEY);
      end

      // stall fills the FIFO, then drains in order
      do_reset();
      stall_pct = 100;
      repeat (10) cycle();
      chk("full_req_off", 32'(bus_if.mem_req_o), 32'd0);
      stall_pct = 0;
      for (int k = 0; k < 5; k++) begin
         chk("drain_pc", bus_if.if_pc_o, 32'(4 * k));
         cycle();
      end
      repeat (6) cycle();

      // slow memory: three wait cycles per request
      ack_mode = 1;
      repeat (40) cycle();

      // redirect while request at 0x20 is pending
      do_reset();
      ack_mode = 1; stall_pct = 0; flush_pct = 0;
      guard = 0;
      while (!(busy && !stale && m_addr == 32'h20 && wcnt == 1) && guard < 300) begin
         cycle();
         guard++;
      end
      chk("reach_0x20_timeout", 32'(guard >= 300), 32'd0);
      ovr_flush = 1'b1; ovr_fpc = 32'h100;
      cycle();
      ovr_flush = 1'b0;
      chk("flush_empty", 32'(bus_if.if_valid_o), 32'd0);
      chk("drop_addr_held", bus_if.mem_addr_o, 32'h20);
      guard = 0;
      while (!bus_if.if_valid_o && guard < 100) begin
         cycle();
         guard++;
      end
      chk("redirect_timeout", 32'(guard >= 100), 32'd0);
      chk("redirect_first_pc", bus_if.if_pc_o, 32'h100);
`ifdef FETCH_STAT_EN
      chk("redirect_drop_cnt", drop_cnt, 32'd1);
      chk("redirect_bubble_cnt", bubble_cnt, m_bubble);
`endif

      // flush coinciding with ack and pop near full
      do_reset();
      ack_mode = 0; stall_pct = 100;
      repeat (8) cycle();
      stall_pct = 0;
      cycle();
      stall_pct = 100;
      guard = 0;
      while (!busy && guard < 20) begin
         cycle();
         guard++;
      end
      chk("refill_timeout", 32'(guard >= 20), 32'd0);
      stall_pct = 0; ovr_flush = 1'b1; ovr_fpc = 32'h243;
      cycle();
      ovr_flush = 1'b0;
      chk("coinc_valid", 32'(bus_if.if_valid_o), 32'd0);
      chk("coinc_req", 32'(bus_if.mem_req_o), 32'd1);
      chk("coinc_addr", bus_if.mem_addr_o, 32'h240);
      repeat (6) cycle();

      // random traffic, including a reset in the middle of transactions
      ack_mode = 2; ack_pct = 60; stall_pct = 30; flush_pct = 4;
      repeat (600) cycle();
      do_reset();
      ack_pct = 90; stall_pct = 15; flush_pct = 2;
      repeat (600) cycle();
      ack_pct = 30; stall_pct = 60; flush_pct = 6;
      repeat (400) cycle();
`ifdef FETCH_STAT_EN
      chk("final_bubble_cnt", bubble_cnt, m_bubble);
      chk("final_drop_cnt", drop_cnt, m_drop);
`endif
      check_outputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
